// File: rtl/mouse_quad.sv
// PS/2 mouse X motion and digital left/right controls to a quadrature pair.
// Mouse deltas go into a saturating signed accumulator that drains one step per tick.
module mouse_quad #(
  parameter int CLKDIV = 5500,
  parameter int ACC_W  = 12,
  parameter int SHIFT  = 0
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       mouse_tgl,
  input  logic [8:0] mouse_dx,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       enc_a,
  output logic       enc_b,
  output logic       busy
);

  localparam int CW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int MAXV = (2 ** (ACC_W - 1)) - 1;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(MAXV);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-MAXV);

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  quad_t                    quad_q, quad_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     tgl_prev_q;
  logic                     busy_q, busy_d;

  logic                     evt, tick, fwd, back, acc_nz;
  logic signed [ACC_W-1:0]  dx_ext, dxs;
  logic signed [ACC_W:0]    sum, stepv, addv;

  assign evt    = (mouse_tgl != tgl_prev_q);
  assign tick   = (cnt_q == CW'(CLKDIV - 1));
  assign acc_nz = (acc_q != '0);
  assign dx_ext = {{(ACC_W - 9){mouse_dx[8]}}, mouse_dx};
  assign dxs    = dx_ext >>> SHIFT;

  // Direction from the pre-update accumulator; buttons only steer an empty one.
  always_comb begin
    fwd  = 1'b0;
    back = 1'b0;
    if (tick) begin
      if (acc_nz) begin
        fwd  = ~acc_q[ACC_W-1];
        back =  acc_q[ACC_W-1];
      end else begin
        fwd  = btn_right & ~btn_left;
        back = btn_left & ~btn_right;
      end
    end
  end

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    addv  = evt ? {dxs[ACC_W-1], dxs} : '0;
    stepv = '0;
    if (acc_nz && fwd)  stepv = (ACC_W + 1)'(1);
    if (acc_nz && back) stepv = '1;
    sum = {acc_q[ACC_W-1], acc_q} + addv - stepv;
    if (sum > SAT_MAX)      acc_d = SAT_MAX[ACC_W-1:0];
    else if (sum < SAT_MIN) acc_d = SAT_MIN[ACC_W-1:0];
    else                    acc_d = sum[ACC_W-1:0];
    busy_d = (acc_d != '0);
  end

  always_comb begin
    quad_d = quad_q;
    if (fwd) begin
      unique case (quad_q)
        Q00: quad_d = Q01;
        Q01: quad_d = Q11;
        Q11: quad_d = Q10;
        Q10: quad_d = Q00;
        default: quad_d = Q00;
      endcase
    end else if (back) begin
      unique case (quad_q)
        Q00: quad_d = Q10;
        Q10: quad_d = Q11;
        Q11: quad_d = Q01;
        Q01: quad_d = Q00;
        default: quad_d = Q00;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    tgl_prev_q <= mouse_tgl;
    if (reset) begin
      quad_q <= Q00;
      cnt_q  <= '0;
      acc_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quad_q <= quad_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      busy_q <= busy_d;
    end
  end

  assign enc_a = quad_q[1];
  assign enc_b = quad_q[0];
  assign busy  = busy_q;

endmodule

// File: tb/tb_mouse_quad.sv
// Randomized and directed bench for mouse_quad against a cycle-level arithmetic model.
module tb_mouse_quad;

  localparam int CLKDIV = 8;
  localparam int ACC_W  = 12;
  localparam int SHIFT  = 0;
  localparam int MAXV   = (2 ** (ACC_W - 1)) - 1;

  logic       clk_sys = 1'b0;
  logic       reset, mouse_tgl, btn_left, btn_right;
  logic [8:0] mouse_dx;
  logic       enc_a, enc_b, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int   m_acc, m_cnt, m_pos;
  bit   m_busy, m_prev;
  logic [1:0] m_enc;

  always #5 clk_sys = ~clk_sys;

  mouse_quad #(.CLKDIV(CLKDIV), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .mouse_tgl(mouse_tgl),
    .mouse_dx (mouse_dx),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .busy     (busy)
  );

  function automatic logic [1:0] pos2enc(input int p);
    case (p)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic void model_update();
    bit evt, tick;
    int dir, t, dxs;
    evt = (mouse_tgl != m_prev);
    m_prev = mouse_tgl;
    if (reset) begin
      m_acc = 0; m_cnt = 0; m_pos = 0; m_busy = 0;
    end else begin
      tick  = (m_cnt == CLKDIV - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
      dir = 0;
      if (tick) begin
        if (m_acc > 0)                     dir = 1;
        else if (m_acc < 0)                dir = -1;
        else if (btn_right && !btn_left)   dir = 1;
        else if (btn_left && !btn_right)   dir = -1;
      end
      m_pos = (m_pos + dir + 4) % 4;
      t   = $signed(mouse_dx);
      dxs = evt ? (t >>> SHIFT) : 0;
      m_acc = m_acc + dxs - ((m_acc != 0) ? dir : 0);
      if (m_acc > MAXV)  m_acc = MAXV;
      if (m_acc < -MAXV) m_acc = -MAXV;
      m_busy = (m_acc != 0);
    end
    m_enc = pos2enc(m_pos);
  endfunction

  // Advance one clock; model sees the same inputs the DUT samples.
  task automatic cyc();
    @(posedge clk_sys);
    model_update();
    #1;
  endtask

  task automatic packet(input int dx);
    mouse_dx  = 9'(dx);
    mouse_tgl = ~mouse_tgl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mouse_tgl = 1'b1; mouse_dx = 9'd5;
    cyc(); cyc(); cyc();
    vectors++;
    if ({enc_a, enc_b, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_state: got %b%b busy=%b, want 00 busy=0", enc_a, enc_b, busy);
    end
    reset = 1'b0;
    repeat (3 * CLKDIV) begin
      cyc();
      vectors++;
      if ({enc_a, enc_b, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_after_reset: got %b%b busy=%b, want 00 busy=0", enc_a, enc_b, busy);
      end
    end
  endtask

  task automatic test_fwd4();
    logic [1:0] seen[$];
    logic [1:0] last;
    logic [1:0] want[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    last = {enc_a, enc_b};
    packet(4);
    repeat (5 * CLKDIV) begin
      cyc();
      vectors++;
      if ({enc_a, enc_b, busy} !== {m_enc, m_busy}) begin
        miscompares++;
        $display("FAIL fwd4: got %b%b busy=%b, want %b busy=%b", enc_a, enc_b, busy, m_enc, m_busy);
      end
      if ({enc_a, enc_b} != last) seen.push_back({enc_a, enc_b});
      last = {enc_a, enc_b};
    end
    vectors++;
    if (seen.size() != 4 || seen[0] !== want[0] || seen[1] !== want[1] ||
        seen[2] !== want[2] || seen[3] !== want[3] || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd4_sequence: got %0d edges busy=%b, want 01,11,10,00 busy=0", seen.size(), busy);
    end
  endtask

  task automatic test_back_then_buttons();
    packet(-3);
    repeat (4 * CLKDIV) begin
      cyc();
      vectors++;
      if ({enc_a, enc_b, busy} !== {m_enc, m_busy}) begin
        miscompares++;
        $display("FAIL back3: got %b%b busy=%b, want %b busy=%b", enc_a, enc_b, busy, m_enc, m_busy);
      end
    end
    vectors++;
    if ({enc_a, enc_b, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL back3_end: got %b%b busy=%b, want 01 busy=0", enc_a, enc_b, busy);
    end
    btn_right = 1'b1;
    repeat (2 * CLKDIV) begin
      cyc();
      vectors++;
      if ({enc_a, enc_b, busy} !== {m_enc, m_busy}) begin
        miscompares++;
        $display("FAIL btn_right: got %b%b busy=%b, want %b busy=%b", enc_a, enc_b, busy, m_enc, m_busy);
      end
    end
    btn_right = 1'b0;
  endtask

  task automatic test_both_buttons();
    logic [1:0] hold;
    hold = {enc_a, enc_b};
    btn_left = 1'b1; btn_right = 1'b1;
    repeat (5 * CLKDIV) begin
      cyc();
      vectors++;
      if ({enc_a, enc_b, busy} !== {hold, 1'b0}) begin
        miscompares++;
        $display("FAIL both_buttons: got %b%b busy=%b, want %b busy=0", enc_a, enc_b, busy, hold);
      end
    end
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      packet(255);
      cyc(); cyc();
    end
    vectors++;
    if (m_acc != MAXV - (40 / CLKDIV) && m_acc > MAXV) begin
      miscompares++;
      $display("FAIL sat_model: model acc=%0d exceeds %0d", m_acc, MAXV);
    end
    n = 0;
    while (busy && n < (MAXV + 10) * CLKDIV) begin
      cyc();
      n++;
      vectors++;
      if ({enc_a, enc_b, busy} !== {m_enc, m_busy}) begin
        miscompares++;
        $display("FAIL saturate: got %b%b busy=%b, want %b busy=%b", enc_a, enc_b, busy, m_enc, m_busy);
      end
    end
    vectors++;
    if (busy !== 1'b0 || n > MAXV * CLKDIV) begin
      miscompares++;
      $display("FAIL sat_drain: got busy=%b after %0d cycles, want busy=0 within %0d", busy, n, MAXV * CLKDIV);
    end
  endtask

  task automatic test_tick_align();
    do_reset();
    cyc(); cyc();
    packet(1);
    cyc();
    for (int i = 0; i < CLKDIV && m_cnt != CLKDIV - 1; i++) begin
      cyc();
      vectors++;
      if ({enc_a, enc_b, busy} !== {m_enc, m_busy}) begin
        miscompares++;
        $display("FAIL align_wait: got %b%b busy=%b, want %b busy=%b", enc_a, enc_b, busy, m_enc, m_busy);
      end
    end
    packet(1);
    cyc();
    vectors++;
    if ({enc_a, enc_b, busy} !== 3'b011) begin
      miscompares++;
      $display("FAIL tick_align: got %b%b busy=%b, want 01 busy=1", enc_a, enc_b, busy);
    end
    repeat (CLKDIV) cyc();
    vectors++;
    if ({enc_a, enc_b, busy} !== 3'b110) begin
      miscompares++;
      $display("FAIL tick_align_drain: got %b%b busy=%b, want 11 busy=0", enc_a, enc_b, busy);
    end
  endtask

  task automatic test_reset_mid();
    packet(-100);
    repeat (3 * CLKDIV) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    vectors++;
    if ({enc_a, enc_b, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid: got %b%b busy=%b, want 00 busy=0", enc_a, enc_b, busy);
    end
    repeat (3 * CLKDIV) begin
      cyc();
      vectors++;
      if ({enc_a, enc_b, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_mid_idle: got %b%b busy=%b, want 00 busy=0", enc_a, enc_b, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) packet(int'($urandom_range(0, 511)) - 256);
      if ($urandom_range(0, 49) == 0) begin
        btn_left  = 1'($urandom_range(0, 1));
        btn_right = 1'($urandom_range(0, 1));
      end
      cyc();
      vectors++;
      if ({enc_a, enc_b, busy} !== {m_enc, m_busy}) begin
        miscompares++;
        $display("FAIL random[%0d]: got %b%b busy=%b, want %b busy=%b", i, enc_a, enc_b, busy, m_enc, m_busy);
      end
    end
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mouse_tgl = 1'b0; mouse_dx = '0;
    btn_left = 1'b0; btn_right = 1'b0;
    m_acc = 0; m_cnt = 0; m_pos = 0; m_busy = 0; m_prev = 0; m_enc = 2'b00;
    #1;
    test_reset();
    test_fwd4();
    test_back_then_buttons();
    test_both_buttons();
    test_saturate();
    test_tick_align();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
